core_sequencer: RTL

//  Drives one neural core through a full pass. Forward pass: streams an N-element input vector

---
 rtl/core_pkg.sv | 17 +
 rtl/core_sequencer_if.sv | 16 +
 rtl/core_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Types and constants shared by the neural core and its sequencer.
package core_pkg;

  localparam int DW = 16;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_BWD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    STREAM,
    WAIT_VLD,
    DONE
  } state_e;

endpackage

// File: rtl/core_sequencer_if.sv
// Sequencer-to-core link: one beat per rdy cycle, pass-level fwd/bwd flags, single-cycle result.
interface core_sequencer_if;
  import core_pkg::*;

  logic          rdy;
  logic          forward;
  logic          backward;
  logic [DW-1:0] x;
  logic [DW-1:0] e;
  logic          vld;
  logic [DW-1:0] y;

  modport master (output rdy, forward, backward, x, e, input vld, y);
  modport slave  (input rdy, forward, backward, x, e, output vld, y);

endinterface

// File: rtl/core_sequencer.sv
// Streams N x-buffer words into the core per pass and captures its forward result.
// Latency: start->done is N+2 (bwd) or N+2+core latency (fwd); no backpressure, start is ignored while busy.
module core_sequencer
  import core_pkg::*;
#(
  parameter int N       = 100,
  parameter int AW      = 7,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic           mode_i,
  input  logic [DW-1:0]  e_in_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic [DW-1:0]  y_out_o,
  output logic           x_rd_o,
  output logic [AW-1:0]  x_addr_o,
  input  logic [DW-1:0]  x_data_i,
  core_sequencer_if.master core
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] LAST     = AW'(N - 1);
  localparam int            TF       = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
  localparam logic [TW-1:0] TMO_FIRE = TW'(TF);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] e_q, e_d;
  logic [DW-1:0] y_q, y_d;
  logic          err_q, err_d;
  logic [AW-1:0] beat_q, beat_d;
  logic [AW-1:0] x_addr_q, x_addr_d;
  logic          x_rd_q, x_rd_d;
  logic [TW-1:0] tmo_q, tmo_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_FWD;
      e_q      <= '0;
      y_q      <= '0;
      err_q    <= 1'b0;
      beat_q   <= '0;
      x_addr_q <= '0;
      x_rd_q   <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      e_q      <= e_d;
      y_q      <= y_d;
      err_q    <= err_d;
      beat_q   <= beat_d;
      x_addr_q <= x_addr_d;
      x_rd_q   <= x_rd_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    e_d      = e_q;
    y_d      = y_q;
    err_d    = err_q;
    beat_d   = beat_q;
    x_addr_d = x_addr_q;
    x_rd_d   = x_rd_q;
    tmo_d    = tmo_q;

    // Read pointer runs one word ahead of the beat and stops after word N-1.
    if (x_rd_q) begin
      x_addr_d = x_addr_q + AW'(1);
      x_rd_d   = (x_addr_q != LAST);
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = FETCH;
          mode_d   = mode_i;
          e_d      = e_in_i;
          err_d    = 1'b0;
          beat_d   = '0;
          tmo_d    = '0;
          x_rd_d   = 1'b1;
          x_addr_d = '0;
        end
      end
      FETCH: state_d = STREAM;
      STREAM: begin
        beat_d = beat_q + AW'(1);
        if (beat_q == LAST) begin
          state_d = (mode_q == MODE_FWD) ? WAIT_VLD : DONE;
        end
      end
      WAIT_VLD: begin
        tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
        // Firing at TIMEOUT-2 lands done exactly TIMEOUT cycles after the last beat.
        if (core.vld) begin
          y_d     = core.y;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (tmo_q == TMO_FIRE) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        x_addr_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o        = (state_q == FETCH) || (state_q == STREAM) || (state_q == WAIT_VLD);
  assign done_o        = (state_q == DONE);
  assign err_o         = done_o && err_q;
  assign y_out_o       = y_q;
  assign x_rd_o        = x_rd_q;
  assign x_addr_o      = x_addr_q;

  assign core.rdy      = (state_q == STREAM);
  assign core.forward  = (mode_q == MODE_FWD) && ((state_q == STREAM) || (state_q == WAIT_VLD));
  assign core.backward = (mode_q == MODE_BWD) && (state_q == STREAM);
  assign core.x        = core.rdy ? x_data_i : '0;
  assign core.e        = e_q;

endmodule
